// File: rtl/sram_adapter_pkg.sv
// -----------------------------------------------------------------------------
// sram_adapter_pkg
//   Shared definitions for the SRAM read-modify-write adapter:
//     state_e     - adapter FSM states
//     lane_of_bit - maps a data bit to the byte-enable lane that owns it.
//                   When ByteWidth does not divide DataWidth, the top lane
//                   owns the leftover high bits.
//     merge_bit   - single-bit byte-lane merge (new data when lane enabled)
// -----------------------------------------------------------------------------
package sram_adapter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RMW_RD,
      RMW_WR,
      RESP
   } state_e;

   function automatic int lane_of_bit(input int bit_idx,
                                      input int byte_width,
                                      input int be_width);
      int lane;
      lane = bit_idx / byte_width;
      if (lane > be_width - 1) lane = be_width - 1;
      return lane;
   endfunction

   function automatic logic merge_bit(input logic old_bit,
                                      input logic new_bit,
                                      input logic lane_en);
      return lane_en ? new_bit : old_bit;
   endfunction

endpackage

// File: rtl/sram_be_merge.sv
// -----------------------------------------------------------------------------
// sram_be_merge
//   Combinational byte-lane merge: each bit of 'merged' takes 'new_data' when
//   the byte enable of its lane is set, otherwise 'old_data'.
//   Ports:
//     old_data  in  DataWidth  word read back from memory
//     new_data  in  DataWidth  captured write data
//     be        in  BeWidth    captured byte enables
//     merged    out DataWidth  word to write back
// -----------------------------------------------------------------------------
module sram_be_merge
   import sram_adapter_pkg::*;
#(
   parameter int DataWidth = 128,
   parameter int ByteWidth = 8,
   localparam int BeWidth  = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic [DataWidth-1:0] old_data,
   input  logic [DataWidth-1:0] new_data,
   input  logic [BeWidth-1:0]   be,
   output logic [DataWidth-1:0] merged
);

   for (genvar b = 0; b < DataWidth; b++) begin : g_bit
      localparam int Lane = lane_of_bit(b, ByteWidth, BeWidth);
      assign merged[b] = merge_bit(old_data[b], new_data[b], be[Lane]);
   end

endmodule

// File: rtl/sram_rmw_adapter.sv
// -----------------------------------------------------------------------------
// sram_rmw_adapter
//   Turns byte-enabled read/write requests into accesses on a whole-word-only
//   SRAM port. Partial writes become a read, a byte merge and a full-word
//   write. One request is in flight at a time; exactly one response per
//   request, in order.
//   Ports:
//     clk_i, rst_i                       clock, async active-high reset
//     req_valid_i/req_ready_o            request handshake
//     req_we_i, req_addr_i, req_wdata_i,
//     req_be_i                           request payload
//     rsp_valid_o/rsp_ready_i            response handshake
//     rsp_rdata_o                        read data ('0 for writes)
//     mem_req_o, mem_we_o, mem_addr_o,
//     mem_wdata_o, mem_be_o              memory port (be tied all-ones)
//     mem_rdata_i                        memory read data, 1-cycle latency
// -----------------------------------------------------------------------------
module sram_rmw_adapter
   import sram_adapter_pkg::*;
#(
   parameter int NumWords   = 1024,
   parameter int DataWidth  = 128,
   parameter int ByteWidth  = 8,
   localparam int AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
   localparam int BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 req_we_i,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [DataWidth-1:0] req_wdata_i,
   input  logic [BeWidth-1:0]   req_be_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [DataWidth-1:0] rsp_rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [BeWidth-1:0]   mem_be_o,
   input  logic [DataWidth-1:0] mem_rdata_i
);

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q;
   logic [DataWidth-1:0] wdata_q;   // captured write data, then merged word
   logic [DataWidth-1:0] rdata_q;
   logic [BeWidth-1:0]   be_q;
   logic [DataWidth-1:0] merged;
   logic                 hs;
   logic                 be_full;
   logic                 be_zero;

   // Gated by rst_i so nothing is accepted while reset is held.
   assign req_ready_o = (state_q == IDLE) && !rst_i;
   assign hs          = req_valid_i && req_ready_o;
   assign be_full     = &req_be_i;
   assign be_zero     = ~|req_be_i;

   // Response comes straight from state/registers: no path from rsp_ready_i.
   assign rsp_valid_o = (state_q == RESP);
   assign rsp_rdata_o = rdata_q;
   assign mem_be_o    = '1;

   sram_be_merge #(
      .DataWidth(DataWidth),
      .ByteWidth(ByteWidth)
   ) u_merge (
      .old_data(mem_rdata_i),
      .new_data(wdata_q),
      .be      (be_q),
      .merged  (merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (state_q)
         IDLE: begin
            if (hs) begin
               if (!req_we_i) begin
                  mem_req_o  = 1'b1;
                  mem_addr_o = req_addr_i;
                  state_d    = RD_WAIT;
               end else if (be_zero) begin
                  // nothing to write: answer without touching memory
                  state_d = RESP;
               end else if (be_full) begin
                  mem_req_o   = 1'b1;
                  mem_we_o    = 1'b1;
                  mem_addr_o  = req_addr_i;
                  mem_wdata_o = req_wdata_i;
                  state_d     = RESP;
               end else begin
                  // partial write: fetch the old word first
                  mem_req_o  = 1'b1;
                  mem_addr_o = req_addr_i;
                  state_d    = RMW_RD;
               end
            end
         end
         RD_WAIT: state_d = RESP;
         RMW_RD:  state_d = RMW_WR;
         RMW_WR: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = addr_q;
            mem_wdata_o = wdata_q;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         be_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (hs) begin
                  addr_q  <= req_addr_i;
                  wdata_q <= req_wdata_i;
                  be_q    <= req_be_i;
                  // writes answer with zero; reads overwrite in RD_WAIT
                  rdata_q <= '0;
               end
            end
            RD_WAIT: rdata_q <= mem_rdata_i;
            RMW_RD:  wdata_q <= merged;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_rmw_adapter.sv
// -----------------------------------------------------------------------------
// tb_sram_rmw_adapter
//   Directed and randomized checks of sram_rmw_adapter with a 16 x 32-bit
//   memory model (1-cycle read latency). Inputs change on the falling edge;
//   outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_sram_rmw_adapter;

   localparam int AW = 4;
   localparam int DW = 32;
   localparam int BW = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic [BW-1:0] req_be_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [DW-1:0] rsp_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_rdata_i;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   sram_rmw_adapter #(.NumWords(16), .DataWidth(DW), .ByteWidth(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i),
      .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i)
   );

   // memory model
   logic [DW-1:0] mem [16];
   logic [DW-1:0] rd_q = '0;
   int wr_cnt = 0;
   int req_cnt = 0;
   assign mem_rdata_i = rd_q;

   always @(posedge clk_i) begin
      if (mem_req_o) begin
         req_cnt <= req_cnt + 1;
         if (mem_we_o) begin
            mem[mem_addr_o] <= mem_wdata_o;
            wr_cnt <= wr_cnt + 1;
         end else begin
            rd_q <= mem[mem_addr_o];
         end
      end
   end

   // advance to the next cycle; request/response strobes are one-shot
   task automatic step();
      @(negedge clk_i);
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b0;
      #1;
   endtask

   task automatic drive_req(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] be);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = a;
      req_wdata_i = d;
      req_be_i    = be;
   endtask

   task automatic test_reset();
      #1;
      checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid_o); end
      checks++; if ({mem_req_o, mem_we_o} !== 2'b00) begin errors++; $display("FAIL rst_mem_req got %b exp 00", {mem_req_o, mem_we_o}); end
      checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata_o); end
      checks++; if (mem_addr_o !== 4'h0 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL rst_mem_bus got %h/%h exp 0/0", mem_addr_o, mem_wdata_o); end
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready_o); end
   endtask

   task automatic test_full_write_read();
      int w0;
      w0 = wr_cnt;
      step();
      drive_req(1'b1, 4'd3, 32'hDEADBEEF, 4'hF);
      #1;
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'd3, 32'hDEADBEEF})
         begin errors++; $display("FAIL fw_mem got %b%b a=%h d=%h exp 11 a=3 d=deadbeef", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      checks++; if (mem_be_o !== 4'hF) begin errors++; $display("FAIL fw_be got %h exp f", mem_be_o); end
      step();
      checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL fw_rsp got v=%b d=%h exp v=1 d=0", rsp_valid_o, rsp_rdata_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL fw_resp_memreq got %b exp 0", mem_req_o); end
      rsp_ready_i = 1'b1;
      step();
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fw_back_idle got %b exp 1", req_ready_o); end
      drive_req(1'b0, 4'd3, 32'h0, 4'h0);
      #1;
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 4'd3}) begin errors++; $display("FAIL rd_mem got %b%b a=%h exp 10 a=3", mem_req_o, mem_we_o, mem_addr_o); end
      step();
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rd_t1_valid got %b exp 0", rsp_valid_o); end
      step();
      checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL rd_t2 got v=%b d=%h exp v=1 d=deadbeef", rsp_valid_o, rsp_rdata_o); end
      checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL fw_write_count got %0d exp 1", wr_cnt - w0); end
   endtask

   task automatic test_backpressure();
      int r0;
      // still in RESP of the previous read of addr 3
      r0 = req_cnt;
      for (int i = 0; i < 4; i++) begin
         checks++; if ({rsp_valid_o, rsp_rdata_o, req_ready_o, mem_req_o} !== {1'b1, 32'hDEADBEEF, 2'b00})
            begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b mreq=%b", i, rsp_valid_o, rsp_rdata_o, req_ready_o, mem_req_o); end
         step();
      end
      checks++; if (req_cnt !== r0) begin errors++; $display("FAIL bp_mem_access got %0d exp %0d", req_cnt, r0); end
      rsp_ready_i = 1'b1;
      step();
      checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL bp_release got %b exp 01", {rsp_valid_o, req_ready_o}); end
   endtask

   task automatic test_partial_write();
      // preload addr 5 with a full write
      drive_req(1'b1, 4'd5, 32'h11223344, 4'hF);
      step(); rsp_ready_i = 1'b1; step();
      drive_req(1'b1, 4'd5, 32'hAABBCCDD, 4'h5);
      #1;
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 4'd5}) begin errors++; $display("FAIL pw_t0 got %b%b a=%h exp 10 a=5", mem_req_o, mem_we_o, mem_addr_o); end
      step();
      checks++; if ({mem_req_o, rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL pw_t1 got %b exp 00", {mem_req_o, rsp_valid_o}); end
      step();
      checks++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 4'd5, 32'h11BB33DD})
         begin errors++; $display("FAIL pw_t2 got %b%b a=%h d=%h exp 11 a=5 d=11bb33dd", mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); end
      checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL pw_t2_valid got %b exp 0", rsp_valid_o); end
      step();
      checks++; if ({rsp_valid_o, rsp_rdata_o, mem_req_o} !== {1'b1, 32'h0, 1'b0}) begin errors++; $display("FAIL pw_t3 got v=%b d=%h mreq=%b", rsp_valid_o, rsp_rdata_o, mem_req_o); end
      rsp_ready_i = 1'b1;
      step();
   endtask

   task automatic test_zero_be();
      int r0;
      drive_req(1'b1, 4'd7, 32'h01234567, 4'hF);
      step(); rsp_ready_i = 1'b1; step();
      r0 = req_cnt;
      drive_req(1'b1, 4'd7, 32'hFFFFFFFF, 4'h0);
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL z_t0_memreq got %b exp 0", mem_req_o); end
      step();
      checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL z_t1 got v=%b d=%h exp v=1 d=0", rsp_valid_o, rsp_rdata_o); end
      checks++; if (req_cnt !== r0) begin errors++; $display("FAIL z_no_access got %0d exp %0d", req_cnt, r0); end
      rsp_ready_i = 1'b1;
      step();
      drive_req(1'b0, 4'd7, 32'h0, 4'h0);
      step(); step();
      checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h01234567}) begin errors++; $display("FAIL z_readback got v=%b d=%h exp v=1 d=01234567", rsp_valid_o, rsp_rdata_o); end
      rsp_ready_i = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      int w0;
      w0 = wr_cnt;
      drive_req(1'b1, 4'd5, 32'hFFFFFFAA, 4'h1);
      step();               // RMW_RD
      rst_i = 1'b1;
      #1;
      checks++; if ({req_ready_o, rsp_valid_o, mem_req_o, mem_we_o} !== 4'b0000)
         begin errors++; $display("FAIL mid_rst_outs got %b exp 0000", {req_ready_o, rsp_valid_o, mem_req_o, mem_we_o}); end
      checks++; if ({rsp_rdata_o, mem_addr_o, mem_wdata_o} !== '0) begin errors++; $display("FAIL mid_rst_data got %h/%h/%h exp 0", rsp_rdata_o, mem_addr_o, mem_wdata_o); end
      step(); step();
      rst_i = 1'b0;
      #1;
      checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_release_ready got %b exp 1", req_ready_o); end
      step(); step(); step();
      checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL mid_no_write got %0d exp %0d", wr_cnt, w0); end
      drive_req(1'b0, 4'd5, 32'h0, 4'h0);
      step(); step();
      checks++; if ({rsp_valid_o, rsp_rdata_o} !== {1'b1, 32'h11BB33DD}) begin errors++; $display("FAIL mid_readback got v=%b d=%h exp v=1 d=11bb33dd", rsp_valid_o, rsp_rdata_o); end
      rsp_ready_i = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      localparam int N = 56;
      logic [DW-1:0] ref_mem [16];
      logic [DW-1:0] exp_q [$];
      int got;
      got = 0;
      fork
         begin : driver
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [BW-1:0] be;
            int            guard;
            for (int i = 0; i < N; i++) begin
               @(negedge clk_i);
               // first 16 ops fill the whole memory so later reads are defined
               if (i < 16) begin
                  we = 1'b1; a = AW'(i); be = 4'hF;
               end else begin
                  we = ($urandom_range(0, 1) == 1);
                  a  = AW'($urandom_range(0, 15));
                  be = BW'($urandom_range(0, 15));
               end
               d = $urandom;
               drive_req(we, a, d, be);
               #1;
               guard = 0;
               while (!req_ready_o && guard < 200) begin
                  @(negedge clk_i); #1; guard++;
               end
               if (guard >= 200) begin
                  errors++; $display("FAIL b2b_req_timeout op %0d", i);
                  break;
               end
               if (we) begin
                  for (int b = 0; b < BW; b++)
                     if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
                  exp_q.push_back(32'h0);
               end else begin
                  exp_q.push_back(ref_mem[a]);
               end
            end
            @(negedge clk_i);
            req_valid_i = 1'b0;
         end
         begin : responder
            int cyc;
            logic [DW-1:0] e;
            cyc = 0;
            while (got < N && cyc < 4000) begin
               @(negedge clk_i);
               rsp_ready_i = ($urandom_range(0, 2) != 0);
               #1;
               cyc++;
               if (rsp_valid_o && rsp_ready_i) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     errors++; $display("FAIL b2b_extra_rsp got %h", rsp_rdata_o);
                  end else begin
                     e = exp_q.pop_front();
                     if (rsp_rdata_o !== e) begin errors++; $display("FAIL b2b_rsp%0d got %h exp %h", got, rsp_rdata_o, e); end
                  end
                  got++;
               end
            end
         end
      join
      rsp_ready_i = 1'b0;
      checks++; if (got !== N) begin errors++; $display("FAIL b2b_rsp_count got %0d exp %0d", got, N); end
      step();
   endtask

   initial begin
      test_reset();
      test_full_write_read();
      test_backpressure();
      test_partial_write();
      test_zero_be();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_rmw_adapter.md
SRAM_RMW_ADAPTER -- requirements
Module: sram_rmw_adapter

Interface
REQ-001 SHALL have parameter NumWords, default 1024, words in the attached memory.
REQ-002 SHALL have parameter DataWidth, default 128, data word width.
REQ-003 SHALL have parameter ByteWidth, default 8, bits per byte-enable lane.
REQ-004 SHALL derive AddrWidth = max(1, clog2(NumWords)) and BeWidth = ceil(DataWidth/ByteWidth); neither is overridable.
REQ-005 clk_i  in  1  single clock; all logic rising-edge.
REQ-006 rst_i  in  1  reset, asynchronous, active-high.
REQ-007 req_valid_i  in  1  upstream request valid.
REQ-008 req_ready_o  out  1  adapter accepts request.
REQ-009 req_we_i  in  1  1 = write, 0 = read.
REQ-010 req_addr_i  in  AddrWidth  word address.
REQ-011 req_wdata_i  in  DataWidth  write data.
REQ-012 req_be_i  in  BeWidth  write byte enables.
REQ-013 rsp_valid_o  out  1  response valid.
REQ-014 rsp_ready_i  in  1  downstream accepts response.
REQ-015 rsp_rdata_o  out  DataWidth  read data; '0 for write responses.
REQ-016 mem_req_o / mem_we_o  out  1 each  memory-port request and write enable.
REQ-017 mem_addr_o  out  AddrWidth  memory-port address.
REQ-018 mem_wdata_o  out  DataWidth  full-word write data.
REQ-019 mem_be_o  out  BeWidth  tied to all-ones; the memory writes whole words only.
REQ-020 mem_rdata_i  in  DataWidth  memory read data, valid one cycle after a read request.

Function
REQ-021 SHALL implement FSM states IDLE, RD_WAIT, RMW_RD, RMW_WR, RESP.
REQ-022 req_ready_o SHALL be 1 only in IDLE.
REQ-023 Handshake SHALL be req_valid_i & req_ready_o.
REQ-024 Read: in handshake cycle T, drive mem_req_o=1, mem_we_o=0, mem_addr_o=req_addr_i, and go to RD_WAIT.
REQ-025 Read, continued: capture mem_rdata_i at the end of T+1 and go to RESP; rsp_valid_o=1 from T+2.
REQ-026 Full write (req_be_i all-ones): at T, drive mem_req_o=1, mem_we_o=1, mem_wdata_o=req_wdata_i; go to RESP; rsp_valid_o=1 from T+1.
REQ-027 Partial write (be neither all-ones nor zero), cycle T: capture addr/wdata/be and issue a read of addr; go to RMW_RD.
REQ-028 Partial write, cycle T+1: merge the read word per byte (lane i takes req_wdata when be[i]=1, else the old byte) into a register; go to RMW_WR.
REQ-029 Partial write, cycle T+2: write the merged word to the captured address; go to RESP; rsp_valid_o=1 from T+3.
REQ-030 Write with be=0: no memory access; go to RESP; rsp_valid_o=1 from T+1.
REQ-031 In RESP, rsp_valid_o=1 and rsp_rdata_o SHALL be stable until rsp_ready_i; on the handshake, return to IDLE.
REQ-032 rsp_valid_o SHALL NOT depend combinationally on rsp_ready_i; exactly one response per request, in order.
REQ-033 mem_req_o SHALL be 0 in RESP and IDLE-without-handshake; mem_addr_o/mem_wdata_o SHALL be '0 when mem_req_o=0.
REQ-034 If ByteWidth does not divide DataWidth, the top lane SHALL cover the remaining bits.

Reset
REQ-035 While rst_i=1: state=IDLE, req_ready_o=0, rsp_valid_o=0, mem_req_o=0, mem_we_o=0, all data registers '0.
REQ-036 Reset mid-operation SHALL discard the in-flight request; no memory write SHALL issue for it after deassertion.
REQ-037 req_ready_o SHALL be 1 in the first cycle after rst_i deasserts.

Structure
REQ-038 Package sram_adapter_pkg SHALL hold the FSM state enum.
REQ-039 Package sram_adapter_pkg SHALL also hold the byte-lane merge function.
REQ-040 Sub-module sram_be_merge (combinational byte merge) SHALL be used; the top level instantiates one adapter per memory port.

Verification (NumWords=16, DataWidth=32, ByteWidth=8; bench memory model with 1-cycle read)
REQ-041 Write addr 3 = 0xDEADBEEF, be=0xF, then read addr 3 -> one memory write; rsp_rdata_o = 0xDEADBEEF at T+2 of the read.
REQ-042 Preload addr 5 = 0x11223344; write 0xAABBCCDD with be=0x5 -> read at T, write of 0x11BB33DD at T+2, rsp_valid_o at T+3.
REQ-043 Write be=0 to addr 7 -> no mem_req_o; rsp_valid_o at T+1 with rdata 0; memory unchanged.
REQ-044 Hold rsp_ready_i=0 for 4 cycles after a read -> rsp_valid_o and rsp_rdata_o stable, req_ready_o=0 throughout, no memory access.
REQ-045 Assert rst_i during RMW_RD of a partial write -> no write reaches memory; all outputs at reset values; req_ready_o=1 the cycle after release.
REQ-046 Back-to-back random reads/writes with random rsp_ready_i, checked against a reference model -> every response matches, in order, none lost.
